aes_key_expander: RTL and testbench
===================================

AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

Interface
REQ-001 Parameter: Nb, 128, width in bits of cipher key and round key; only 128 is supported.
REQ-002 Parameter: NR, 10, number of AES-128 rounds; round indices run 0..NR.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; forces the block to IDLE immediately, independent of clk.
REQ-005 start  input  1  request to expand cipher_key; sampled only in IDLE.
REQ-006 cipher_key  input  Nb  128-bit AES cipher key, byte 0 in bits [127:120].
REQ-007 key_ready  input  1  downstream round consumer accepts round_key this cycle.
REQ-008 round_key  output  Nb  current round key, same byte order as cipher_key.
REQ-009 round_idx  output  4  index of round_key, 0..10.
REQ-010 key_valid  output  1  round_key and round_idx are valid.
REQ-011 busy  output  1  expansion in progress; high from the capture edge to the final transfer.
REQ-012 done  output  1  one-cycle pulse after the round-10 key is accepted.

Function
REQ-013 FSM states: IDLE, EMIT; the state register changes only on clk edges or on reset.
REQ-014 IDLE with start=1 at an edge -> register cipher_key into round_key, round_idx=0, key_valid=1, busy=1, state EMIT.
REQ-015 Transfer = key_valid && key_ready at a rising edge.
REQ-016 EMIT, no transfer -> round_key, round_idx and key_valid hold unchanged; there is no timeout.
REQ-017 EMIT, transfer with round_idx<10 -> round_key becomes the next FIPS-197 round key, round_idx increments by 1, key_valid stays 1.
REQ-018 Next-key rule: w4=w0^SubWord(RotWord(w3))^Rcon[idx+1]; w5=w1^w4; w6=w2^w5; w7=w3^w6 (32-bit words, w0 is MSW).
REQ-019 Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 in the top byte of the word, other bytes zero.
REQ-020 SubWord uses the standard AES forward S-box, with four combinational lookups.
REQ-021 EMIT, transfer with round_idx=10 -> key_valid=0, busy=0, done=1 for exactly one cycle, state IDLE, round_idx=0.
REQ-022 With key_ready held 1, round 0 is valid on the cycle after capture and round k on cycle k after capture; done is asserted on cycle 11 after capture.
REQ-023 start while busy=1 is ignored, and cipher_key changes during EMIT have no effect.
REQ-024 start=1 on the same edge as the round-10 transfer is ignored; a new start is accepted only from the following cycle (back-to-back gap of at least one cycle).
REQ-025 round_key is held stable when key_valid=0; its value is don't-care after done.
REQ-026 All outputs are registered; there is no combinational path from any input to any output.

Reset
REQ-027 reset=0 asynchronously forces state IDLE, round_key=0, round_idx=0, key_valid=0, busy=0, done=0.
REQ-028 reset asserted mid-expansion aborts the expansion with no done pulse.
REQ-029 After reset deasserts, the first start at an edge restarts from round 0.

Verification
REQ-030 Reset with reset=0, then release -> all outputs 0; start=0 for 5 cycles -> outputs remain 0.
REQ-031 cipher_key=2b7e151628aed2a6abf7158809cf4f3c, start pulse, key_ready=1 -> idx0=2b7e...4f3c; idx1=a0fafe1788542cb123a339392a6c7605; idx10=d014f9a8c9ee2589e13f0cc8b6630ca6; done on cycle 11.
REQ-032 cipher_key=000102030405060708090a0b0c0d0e0f -> idx1=d6aa74fdd2af72fadaa678f1d6ab76fe; idx10=13111d7fe3944a17f307a78b4d2b30c5.
REQ-033 Backpressure: key_ready toggles 1,0,0,1 repeatedly -> each index is presented once and held while key_ready=0; the key sequence is identical to REQ-031; done follows the idx10 transfer.
REQ-034 reset pulsed low asynchronously at idx5 -> outputs go to 0 at once; a new start with the REQ-032 key yields the correct idx0..idx10 sequence.
REQ-035 start held high through the whole expansion and the done cycle -> no re-capture while busy; a new expansion begins one cycle after done.

Source files
------------

// File: rtl/aes_key_expander.sv
// AES-128 key expander: captures a cipher key on start and streams round keys
// 0..NR over a valid/ready handshake, computing each next round key on the fly
// from the current one. done pulses for one cycle after the last key is taken.
module aes_key_expander #(
    parameter int Nb = 128,
    parameter int NR = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [Nb-1:0] cipher_key,
    input  logic          key_ready,
    output logic [Nb-1:0] round_key,
    output logic [3:0]    round_idx,
    output logic          key_valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    // Forward S-box, entry 0 in the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    // Round constant for the key being produced (1..10); top byte only.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_t      state, state_nxt;
    logic        xfer;
    logic        last_xfer;
    logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
    logic [31:0] temp_w;
    logic [Nb-1:0] next_key;
    logic [Nb-1:0] round_key_nxt;
    logic [3:0]    round_idx_nxt;
    logic          key_valid_nxt;
    logic          busy_nxt;
    logic          done_nxt;

    assign xfer      = key_valid && key_ready;
    assign last_xfer = xfer && (round_idx == LAST_IDX);

    // Next round key from the currently presented one (w0 is the most significant word).
    always_comb begin
        w0       = round_key[127:96];
        w1       = round_key[95:64];
        w2       = round_key[63:32];
        w3       = round_key[31:0];
        temp_w   = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(round_idx + 4'd1), 24'h000000};
        w4       = w0 ^ temp_w;
        w5       = w1 ^ w4;
        w6       = w2 ^ w5;
        w7       = w3 ^ w6;
        next_key = {w4, w5, w6, w7};
    end

    // State register; reset drops straight back to IDLE, aborting any expansion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: start only matters in IDLE, so a start on the final transfer edge is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EMIT;
            EMIT:    if (last_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds unless captured or transferred.
    always_comb begin
        round_key_nxt = round_key;
        round_idx_nxt = round_idx;
        key_valid_nxt = key_valid;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    round_key_nxt = cipher_key;
                    round_idx_nxt = 4'd0;
                    key_valid_nxt = 1'b1;
                    busy_nxt      = 1'b1;
                end
            end
            EMIT: begin
                if (last_xfer) begin
                    round_idx_nxt = 4'd0;
                    key_valid_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                    done_nxt      = 1'b1;
                end else if (xfer) begin
                    round_key_nxt = next_key;
                    round_idx_nxt = round_idx + 4'd1;
                end
            end
            default: begin
                key_valid_nxt = 1'b0;
                busy_nxt      = 1'b0;
            end
        endcase
    end

    // Output registers, so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            round_key <= '0;
            round_idx <= 4'd0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            round_key <= round_key_nxt;
            round_idx <= round_idx_nxt;
            key_valid <= key_valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: a FIPS-197 word-by-word key schedule (S-box
// derived from GF(2^8) inversion) plus a transaction-level handshake model,
// compared against the DUT on every falling edge.
module tb_aes_key_expander;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] cipher_key;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    aes_key_expander #(.Nb(128), .NR(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cipher_key (cipher_key),
        .key_ready  (key_ready),
        .round_key  (round_key),
        .round_idx  (round_idx),
        .key_valid  (key_valid),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox_tab [256];

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Round key r of the FIPS-197 schedule for cipher key k.
    function automatic logic [127:0] rk_of(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        int          ri;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t  = t ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        ri = int'(r);
        return {w[4*ri], w[4*ri+1], w[4*ri+2], w[4*ri+3]};
    endfunction

    // ---------------- transaction model ----------------
    logic         m_valid = 1'b0;
    logic         m_busy  = 1'b0;
    logic         m_done  = 1'b0;
    logic         m_zero  = 1'b1;
    logic [3:0]   m_idx   = 4'd0;
    logic [127:0] m_key   = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_zero  <= 1'b1;
            m_idx   <= 4'd0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_key   <= cipher_key;
                    m_idx   <= 4'd0;
                    m_valid <= 1'b1;
                    m_busy  <= 1'b1;
                    m_zero  <= 1'b0;
                end
            end else if (key_ready) begin
                if (m_idx == 4'd10) begin
                    m_valid <= 1'b0;
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                    m_idx   <= 4'd0;
                end else begin
                    m_idx <= m_idx + 4'd1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("key_valid", 128'(key_valid), 128'(m_valid));
        chk("busy",      128'(busy),      128'(m_busy));
        chk("done",      128'(done),      128'(m_done));
        chk("round_idx", 128'(round_idx), 128'(m_idx));
        if (m_valid)     chk("round_key", round_key, rk_of(m_key, m_idx));
        else if (m_zero) chk("round_key_reset", round_key, 128'h0);
    endtask

    // One clock: wait for the falling edge and compare everything there.
    task automatic cycle();
        @(negedge clk);
        compare_all();
    endtask

    // mode 0: ready=1; 1: ready 1,0,0,1 pattern; 2: random ready; 3: ready=1 with start held high.
    task automatic run_exp(input logic [127:0] key, input int mode, input bit lit_en,
                           input logic [127:0] lit1, input logic [127:0] lit10, output int cycles);
        bit         seen;
        logic [3:0] pat;
        pat    = 4'b1001;
        seen   = 1'b0;
        cycles = 0;
        cipher_key = key;
        start      = 1'b1;
        key_ready  = 1'b1;
        for (int j = 0; j < 300 && !seen; j++) begin
            cycle();
            cycles++;
            if (lit_en && key_valid) begin
                if (round_idx == 4'd0)  chk("lit_idx0",  round_key, key);
                if (round_idx == 4'd1)  chk("lit_idx1",  round_key, lit1);
                if (round_idx == 4'd10) chk("lit_idx10", round_key, lit10);
            end
            if (done) seen = 1'b1;
            if (mode != 3) start = 1'b0;
            cipher_key = {$urandom(), $urandom(), $urandom(), $urandom()};
            case (mode)
                1:       key_ready = pat[j % 4];
                2:       key_ready = 1'($urandom_range(0, 1));
                default: key_ready = 1'b1;
            endcase
        end
        chk("done_seen", 128'(seen), 128'(1));
    endtask

    initial begin
        logic [7:0] inv;
        int         cyc;
        logic [127:0] rkey;

        reset      = 1'b0;
        start      = 1'b0;
        key_ready  = 1'b0;
        cipher_key = '0;

        // S-box from multiplicative inverse plus affine map.
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        // Pin the model to known values.
        chk("model_sbox_00", 128'(sbox_tab[0]),     128'h63);
        chk("model_sbox_53", 128'(sbox_tab[8'h53]), 128'hed);
        chk("model_k1_r1",   rk_of(K1, 4'd1),  K1_R1);
        chk("model_k1_r10",  rk_of(K1, 4'd10), K1_R10);
        chk("model_k2_r1",   rk_of(K2, 4'd1),  K2_R1);
        chk("model_k2_r10",  rk_of(K2, 4'd10), K2_R10);

        // Reset state, held asynchronously before any clock edge.
        #3;
        chk("rst_key_valid", 128'(key_valid), 128'h0);
        chk("rst_busy",      128'(busy),      128'h0);
        chk("rst_done",      128'(done),      128'h0);
        chk("rst_round_idx", 128'(round_idx), 128'h0);
        chk("rst_round_key", round_key,       128'h0);
        cycle();
        cycle();
        #2 reset = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // Reference vector with ready held high, including done latency.
        run_exp(K1, 0, 1'b1, K1_R1, K1_R10, cyc);
        chk("done_latency", 128'(cyc - 1), 128'(11));
        cycle();

        // Backpressure 1,0,0,1.
        run_exp(K1, 1, 1'b1, K1_R1, K1_R10, cyc);
        cycle();

        // Abort at idx5 with an asynchronous reset pulse.
        cipher_key = K1;
        start      = 1'b1;
        key_ready  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            start = 1'b0;
            if (key_valid && round_idx == 4'd5) break;
        end
        chk("reached_idx5", 128'(round_idx), 128'(5));
        #2 reset = 1'b0;
        #1;
        chk("abort_key_valid", 128'(key_valid), 128'h0);
        chk("abort_busy",      128'(busy),      128'h0);
        chk("abort_done",      128'(done),      128'h0);
        chk("abort_round_idx", 128'(round_idx), 128'h0);
        chk("abort_round_key", round_key,       128'h0);
        cycle();
        cycle();
        #2 reset = 1'b1;
        cycle();
        run_exp(K2, 0, 1'b1, K2_R1, K2_R10, cyc);
        cycle();

        // start held high through the whole expansion and the done cycle.
        run_exp(K2, 3, 1'b1, K2_R1, K2_R10, cyc);
        rkey = cipher_key;
        cycle();
        chk("restart_valid", 128'(key_valid), 128'(1));
        chk("restart_idx",   128'(round_idx), 128'(0));
        chk("restart_busy",  128'(busy),      128'(1));
        chk("restart_key",   round_key,       rkey);
        start     = 1'b0;
        key_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (done) break;
        end
        cycle();

        // Random keys, random backpressure and idle gaps.
        for (int n = 0; n < 40; n++) begin
            start = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                key_ready = 1'($urandom_range(0, 1));
                cycle();
            end
            run_exp({$urandom(), $urandom(), $urandom(), $urandom()}, (n % 3 == 0) ? 0 : 2,
                    1'b0, 128'h0, 128'h0, cyc);
        end
        start = 1'b0;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
